// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-issue controller: ARM condition codes,
// NZCV bit positions, controller states and the issue payload.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic exec;
    logic set_flags;
  } ex_issue_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-field evaluation against an NZCV value.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_issue_ctrl.sv
// ID->EXE issue controller owning NZCV: condition evaluation, flag-hazard stall
// and post-branch flush. Define COND_FWD_EN to forward returning flags to ID.
module cond_issue_ctrl
  import cond_pkg::*;
#(
  parameter int unsigned PEND_W       = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [3:0]        id_cond,
  input  logic              id_set_flags,
  input  logic              id_is_branch,
  input  logic              flag_we,
  input  logic [3:0]        flag_nzcv,
  output logic              ex_valid,
  output logic              ex_exec,
  output logic              ex_set_flags,
  output logic [3:0]        nzcv,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              proto_err
);

  localparam int unsigned FLUSH_W = 4;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state, state_nxt;
  logic [FLUSH_W-1:0] flush_cnt, flush_cnt_nxt;
  logic              fwd, pass, issue, is_cond, pend_zero, pend_full, inc, dec;
  logic [3:0]        eval_nzcv;
  ex_issue_t         ex_nxt;

`ifdef COND_FWD_EN
  assign fwd = flag_we && (pend_cnt == PEND_W'(1));
`else
  assign fwd = 1'b0;
`endif

  // The only outstanding write is landing now, so its flags can be used directly.
  assign eval_nzcv = fwd ? flag_nzcv : nzcv;
  assign is_cond   = (id_cond != COND_AL);
  assign pend_zero = (pend_cnt == '0);
  assign pend_full = (pend_cnt == PEND_MAX);

  cond_eval u_cond_eval (
    .cond (id_cond),
    .nzcv (eval_nzcv),
    .pass (pass)
  );

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    id_ready      = 1'b0;
    issue         = 1'b0;
    case (state)
      RUN: begin
        if (is_cond && !pend_zero && !fwd) begin
          if (id_valid) state_nxt = STALL;
        end else if (!(id_set_flags && pend_full)) begin
          id_ready = 1'b1;
          issue    = id_valid;
        end
      end
      STALL: begin
        if (fwd) begin
          id_ready  = 1'b1;
          issue     = id_valid;
          state_nxt = RUN;
        end else if (pend_zero) begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        id_ready = 1'b1;
        if (flush_cnt == '0) state_nxt = RUN;
        else flush_cnt_nxt = flush_cnt - FLUSH_W'(1);
      end
      default: state_nxt = RUN;
    endcase
    if (issue && id_is_branch && pass) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = FLUSH_W'(FLUSH_CYCLES - 1);
    end
    if (!rst_n) id_ready = 1'b0;
  end

  assign ex_nxt.valid     = issue;
  assign ex_nxt.exec      = issue & pass;
  assign ex_nxt.set_flags = issue & pass & id_set_flags;
  assign inc = ex_nxt.set_flags;
  assign dec = flag_we & ~pend_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      flush_cnt    <= '0;
      ex_valid     <= 1'b0;
      ex_exec      <= 1'b0;
      ex_set_flags <= 1'b0;
      nzcv         <= '0;
      pend_cnt     <= '0;
      proto_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      flush_cnt    <= flush_cnt_nxt;
      ex_valid     <= ex_nxt.valid;
      ex_exec      <= ex_nxt.exec;
      ex_set_flags <= ex_nxt.set_flags;
      pend_cnt     <= pend_cnt + PEND_W'(inc) - PEND_W'(dec);
      if (flag_we) nzcv <= flag_nzcv;
      if (flag_we && pend_zero) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed plus randomized bench for cond_issue_ctrl against a behavioural model.
module tb_cond_issue_ctrl;

  localparam int unsigned PEND_W       = 3;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int          PEND_MAX     = 7;

  logic              clk, rst_n;
  logic              id_valid, id_ready, id_set_flags, id_is_branch, flag_we;
  logic [3:0]        id_cond, flag_nzcv, nzcv;
  logic              ex_valid, ex_exec, ex_set_flags, proto_err;
  logic [PEND_W-1:0] pend_cnt;

  cond_issue_ctrl #(.PEND_W(PEND_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_cond(id_cond), .id_set_flags(id_set_flags), .id_is_branch(id_is_branch),
    .flag_we(flag_we), .flag_nzcv(flag_nzcv), .ex_valid(ex_valid), .ex_exec(ex_exec),
    .ex_set_flags(ex_set_flags), .nzcv(nzcv), .pend_cnt(pend_cnt), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef COND_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: outstanding writes, flags, sticky error, stall flag,
  // remaining discard cycles and the expected EXE outputs.
  int       m_pend, m_flush;
  logic [3:0] m_nzcv;
  bit       m_err, m_stall, m_exv, m_exe, m_exs;

  // Conditions come in complementary pairs; even code is the base test.
  function automatic bit arm_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_flush = 0; m_nzcv = 4'h0;
    m_err = 0; m_stall = 0; m_exv = 0; m_exe = 0; m_exs = 0;
  endtask

  // One clock cycle: drive, check id_ready, advance model, check registered outputs.
  task automatic step(input logic v, input logic [3:0] c, input logic sf,
                      input logic br, input logic fwe, input logic [3:0] fn);
    bit fwd, rdy, iss, pass, stall_n;
    int pend_old;
    id_valid = v; id_cond = c; id_set_flags = sf; id_is_branch = br;
    flag_we = fwe; flag_nzcv = fn;
    #1;
    fwd = FWD_EN && (m_pend == 1) && fwe;
    stall_n = 1'b0;
    if (m_flush > 0) begin
      rdy = 1; iss = 0;
    end else if (m_stall) begin
      rdy = fwd; iss = v && fwd; stall_n = !fwd && (m_pend != 0);
    end else if (c != 4'hE && m_pend > 0 && !fwd) begin
      rdy = 0; iss = 0; stall_n = v;
    end else if (sf && m_pend == PEND_MAX) begin
      rdy = 0; iss = 0;
    end else begin
      rdy = 1; iss = v;
    end
    chk("id_ready", 8'(id_ready), 8'(rdy));
    pass = arm_cond(c, fwd ? fn : m_nzcv);
    if (iss && br && pass) m_flush = FLUSH_CYCLES;
    else if (m_flush > 0) m_flush--;
    m_stall = stall_n;
    m_exv = iss; m_exe = iss && pass; m_exs = iss && pass && sf;
    pend_old = m_pend;
    m_pend = pend_old + int'(m_exs) - int'(fwe && pend_old > 0);
    if (fwe && pend_old == 0) m_err = 1;
    if (fwe) m_nzcv = fn;
    @(posedge clk);
    @(negedge clk);
    chk("ex_valid", 8'(ex_valid), 8'(m_exv));
    chk("ex_exec", 8'(ex_exec), 8'(m_exe));
    chk("ex_set_flags", 8'(ex_set_flags), 8'(m_exs));
    chk("nzcv", 8'(nzcv), 8'(m_nzcv));
    chk("pend_cnt", 8'(pend_cnt), 8'(m_pend));
    chk("proto_err", 8'(proto_err), 8'(m_err));
  endtask

  task automatic idle(input logic fwe, input logic [3:0] fn);
    step(1'b0, 4'hE, 1'b0, 1'b0, fwe, fn);
  endtask

  initial begin
    bit issued;
    logic [3:0] rc;
    rst_n = 1'b0;
    id_valid = 1'b1; id_cond = 4'hE; id_set_flags = 1'b0; id_is_branch = 1'b0;
    flag_we = 1'b0; flag_nzcv = 4'h0;
    model_reset();
    #2;
    chk("rst_id_ready", 8'(id_ready), 8'h0);
    chk("rst_ex_valid", 8'(ex_valid), 8'h0);
    chk("rst_nzcv", 8'(nzcv), 8'h0);
    chk("rst_pend", 8'(pend_cnt), 8'h0);
    chk("rst_proto_err", 8'(proto_err), 8'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Flag-setting AL, flags return two cycles later.
    step(1, 4'hE, 1, 0, 0, 4'h0);
    chk("t1_pend_up", 8'(pend_cnt), 8'h1);
    idle(0, 4'h0);
    idle(1, 4'b0100);
    chk("t1_pend_down", 8'(pend_cnt), 8'h0);
    chk("t1_nzcv", 8'(nzcv), 8'h4);

    // EQ waits on an in-flight flag write that returns Z=1.
    step(1, 4'hE, 1, 0, 0, 4'h0);
    step(1, 4'h0, 0, 0, 1, 4'b0100);
    issued = m_exv;
    for (int i = 0; i < 4 && !issued; i++) begin
      step(1, 4'h0, 0, 0, 0, 4'h0);
      issued = m_exv;
    end
    chk("t2_eq_exec", 8'(ex_exec), 8'h1);

    // N=1, V=0: GE fails, LT passes, NV never executes nor counts.
    step(1, 4'hE, 1, 0, 0, 4'h0);
    idle(1, 4'b1000);
    step(1, 4'hA, 0, 0, 0, 4'h0);
    chk("t3_ge", 8'(ex_exec), 8'h0);
    step(1, 4'hB, 0, 0, 0, 4'h0);
    chk("t3_lt", 8'(ex_exec), 8'h1);
    step(1, 4'hF, 1, 0, 0, 4'h0);
    chk("t3_nv_exec", 8'(ex_exec), 8'h0);
    chk("t3_nv_pend", 8'(pend_cnt), 8'h0);

    // Taken NE branch followed by three back-to-back instructions.
    step(1, 4'h1, 0, 1, 0, 4'h0);
    chk("t4_branch", 8'(ex_valid), 8'h1);
    step(1, 4'hE, 0, 0, 0, 4'h0);
    chk("t4_drop1", 8'(ex_valid), 8'h0);
    step(1, 4'hE, 0, 0, 0, 4'h0);
    chk("t4_drop2", 8'(ex_valid), 8'h0);
    step(1, 4'hE, 0, 0, 0, 4'h0);
    chk("t4_issue3", 8'(ex_valid), 8'h1);

    // Saturate the outstanding counter, drain it, then a stray return.
    for (int i = 0; i < 7; i++) step(1, 4'hE, 1, 0, 0, 4'h0);
    chk("t5_full", 8'(pend_cnt), 8'h7);
    step(1, 4'hE, 1, 0, 0, 4'h0);
    chk("t5_held", 8'(ex_valid), 8'h0);
    for (int i = 0; i < 7; i++) idle(1, 4'h3);
    idle(1, 4'h2);
    chk("t5_err", 8'(proto_err), 8'h1);
    chk("t5_pend0", 8'(pend_cnt), 8'h0);

    // Reset while stalled.
    step(1, 4'hE, 1, 0, 0, 4'h0);
    step(1, 4'h0, 0, 0, 0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_id_ready", 8'(id_ready), 8'h0);
    chk("rst2_pend", 8'(pend_cnt), 8'h0);
    chk("rst2_proto_err", 8'(proto_err), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(0, 4'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rc = ($urandom % 3 == 0) ? 4'hE : 4'($urandom % 16);
      step(1'($urandom % 4 != 0), rc, 1'($urandom % 2), 1'($urandom % 8 == 0),
           (m_pend > 0) ? 1'($urandom % 3 == 0) : 1'($urandom % 50 == 0),
           4'($urandom % 16));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
